md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Execute-stage multiply/divide unit owning the architectural HI and LO registers.
- Consumes the HI/LO operation code and mfhi/mflo read select produced by the decode-stage control decoder and carried in the E pipeline register.
- Runs multi-cycle mult/multu/div/divu with a busy handshake, performs mthi/mtlo writes, and supplies the mfhi/mflo read value.
- Produces the decode-stage stall request that holds any HI/LO instruction in D while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy duration for div/divu (must be >= 1)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- hiloOpE  input  3  op in E: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 treated as none
- hiloReadE  input  2  read select in E: 10 mfhi, 01 mflo, 00 none
- rsDataE  input  32  forwarded rs value; multiplicand / dividend / mthi-mtlo source
- rtDataE  input  32  forwarded rt value; multiplier / divisor
- isHiloD  input  1  instruction in D is any of mult, multu, div, divu, mfhi, mflo, mthi, mtlo
- start  output  1  combinational: a mult/multu/div/divu is issued this cycle
- busy  output  1  registered: an operation is in flight
- hiloOutE  output  32  combinational: HI when hiloReadE=10, LO when 01, else 0
- mdStallD  output  1  combinational: isHiloD & (start | busy)

Behaviour:
- Reset (asynchronous, rst_n low): HI=0, LO=0, busy=0, counter=0, tempHi=0, tempLo=0, pendingDivZero=0. Any in-flight result is discarded. The first active edge after release behaves as an idle cycle.
- start = (hiloOpE in 001..100) & ~busy.
  - With a correct stall, hiloOpE is never a mult/div op while busy.
  - If such an op does arrive while busy, it is ignored and causes no state change.
- Issue: on the edge where start=1:
  - Compute the result combinationally from rsDataE and rtDataE and latch it into tempHi/tempLo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Set busy=1.
- Arithmetic:
  - mult: {tempHi,tempLo} = 64-bit signed product.
  - multu: {tempHi,tempLo} = 64-bit unsigned product.
  - div: tempLo = signed quotient truncated toward zero; tempHi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (rtDataE=0 on div/divu): pendingDivZero=1. The operation still occupies DIV_CYCLES of busy, but HI/LO are left unchanged at completion.
- Countdown: on each edge while busy, counter decrements. On the edge where counter==1:
  - HI<=tempHi and LO<=tempLo (unless pendingDivZero).
  - busy<=0 and pendingDivZero<=0.
  - busy is therefore high for exactly N cycles after the start cycle.
- Back-to-back: a new start is accepted in the first cycle busy is low, i.e. the cycle after completion.
- mthi/mtlo (101/110), when not busy:
  - On the next edge, HI (or LO) <= rsDataE. Single cycle; start and busy stay 0.
  - If busy, ignored.
- Read: hiloOutE reflects the registered HI/LO combinationally, so an mthi at edge k is visible to an mfhi in E from cycle k+1. No internal bypass from tempHi/tempLo.
- Simultaneous hiloOpE and hiloReadE are decoder-exclusive. If both are asserted, the write/issue proceeds and the read returns the pre-edge value.
- mdStallD covers the start cycle itself, so an md instruction directly behind a mult is held in D.

Decomposition:
- Shared package md_pkg holds:
  - HILO_OP_* encodings (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO)
  - HILO_RD_* encodings (NONE, HI=2'b10, LO=2'b01)
  - default cycle constants
- These encodings are also used by the control decoder.
- One sub-module, md_arith: purely combinational, takes op, a and b, returns resHi, resLo and divZero. md_unit keeps the counter/busy FSM (IDLE/BUSY) and the HI/LO/temp registers.

Test Plan:
- mult rs=FFFFFFFD, rt=00000005:
  - start=1 for 1 cycle, busy=1 for exactly 5 cycles.
  - Then mfhi=FFFFFFFF, mflo=FFFFFFF1.
  - HI/LO unchanged during busy.
- multu rs=FFFFFFFF, rt=00000002 -> HI=00000001, LO=FFFFFFFE after 5 busy cycles.
- div rs=FFFFFFF9 (-7), rt=00000002:
  - busy for 10 cycles.
  - LO=FFFFFFFD, HI=FFFFFFFF.
  - divu with the same operands -> LO=7FFFFFFC, HI=00000001.
- divu rt=0 after HI=11111111, LO=22222222 -> 10 busy cycles, HI/LO remain 11111111/22222222.
- mthi rs=ABCD0123, next cycle mfhi -> hiloOutE=ABCD0123, busy never asserts; mtlo likewise on LO.
- Reset and stall:
  - Assert rst_n=0 mid-div (cycle 4 of 10) -> busy=0, HI=LO=0 immediately.
  - After release, a fresh mult completes normally.
  - isHiloD=1 during start and busy cycles -> mdStallD=1; deasserts the cycle busy falls.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: HI/LO op and read-select encodings shared by the decoder and md_unit.
package md_pkg;

    localparam logic [2:0] HILO_OP_NONE  = 3'b000;
    localparam logic [2:0] HILO_OP_MULT  = 3'b001;
    localparam logic [2:0] HILO_OP_MULTU = 3'b010;
    localparam logic [2:0] HILO_OP_DIV   = 3'b011;
    localparam logic [2:0] HILO_OP_DIVU  = 3'b100;
    localparam logic [2:0] HILO_OP_MTHI  = 3'b101;
    localparam logic [2:0] HILO_OP_MTLO  = 3'b110;

    localparam logic [1:0] HILO_RD_NONE = 2'b00;
    localparam logic [1:0] HILO_RD_HI   = 2'b10;
    localparam logic [1:0] HILO_RD_LO   = 2'b01;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {IDLE, BUSY} md_state_e;

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational mult/multu/div/divu producing the HI/LO result pair.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] resHi,
    output logic [31:0] resLo,
    output logic        divZero
);
    logic [63:0] prod_s, prod_u;
    logic [31:0] b_safe, q_s, r_s, q_u, r_u;

    // Zero divisor is swapped for 1 so the dividers never see 0; result is discarded anyway.
    always_comb begin
        divZero = (op == HILO_OP_DIV || op == HILO_OP_DIVU) && b == 32'd0;
        b_safe  = (b == 32'd0) ? 32'd1 : b;
        prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u  = {32'd0, a} * {32'd0, b};
        q_s     = $signed(a) / $signed(b_safe);
        r_s     = $signed(a) % $signed(b_safe);
        q_u     = a / b_safe;
        r_u     = a % b_safe;
        resHi   = (op == HILO_OP_MULT)  ? prod_s[63:32] :
                  (op == HILO_OP_MULTU) ? prod_u[63:32] :
                  (op == HILO_OP_DIV)   ? r_s :
                  (op == HILO_OP_DIVU)  ? r_u : 32'd0;
        resLo   = (op == HILO_OP_MULT)  ? prod_s[31:0] :
                  (op == HILO_OP_MULTU) ? prod_u[31:0] :
                  (op == HILO_OP_DIV)   ? q_s :
                  (op == HILO_OP_DIVU)  ? q_u : 32'd0;
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit owning HI/LO, with busy handshake
// and decode-stage stall request.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  hiloOpE,
    input  logic [1:0]  hiloReadE,
    input  logic [31:0] rsDataE,
    input  logic [31:0] rtDataE,
    input  logic        isHiloD,
    output logic        start,
    output logic        busy,
    output logic [31:0] hiloOutE,
    output logic        mdStallD
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

    md_state_e   state, state_next;
    logic [CW-1:0] counter;
    logic [31:0] hi, lo, temp_hi, temp_lo, res_hi, res_lo;
    logic        pend_div_zero, div_zero, is_md, is_div;

    md_arith u_arith (
        .op     (hiloOpE),
        .a      (rsDataE),
        .b      (rtDataE),
        .resHi  (res_hi),
        .resLo  (res_lo),
        .divZero(div_zero)
    );

    always_comb begin
        is_md      = hiloOpE >= HILO_OP_MULT && hiloOpE <= HILO_OP_DIVU;
        is_div     = hiloOpE == HILO_OP_DIV || hiloOpE == HILO_OP_DIVU;
        busy       = state == BUSY;
        start      = is_md && !busy;
        mdStallD   = isHiloD && (start || busy);
        hiloOutE   = (hiloReadE == HILO_RD_HI) ? hi : (hiloReadE == HILO_RD_LO) ? lo : 32'd0;
        state_next = state;
        if (state == IDLE && start)
            state_next = BUSY;
        else if (state == BUSY && counter == CW'(1))
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            counter       <= '0;
            hi            <= '0;
            lo            <= '0;
            temp_hi       <= '0;
            temp_lo       <= '0;
            pend_div_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                temp_hi       <= res_hi;
                temp_lo       <= res_lo;
                counter       <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                pend_div_zero <= div_zero;
            end else if (busy) begin
                counter <= counter - CW'(1);
                if (counter == CW'(1)) begin
                    if (!pend_div_zero) begin
                        hi <= temp_hi;
                        lo <= temp_lo;
                    end
                    pend_div_zero <= 1'b0;
                end
            end else if (hiloOpE == HILO_OP_MTHI) begin
                hi <= rsDataE;
            end else if (hiloOpE == HILO_OP_MTLO) begin
                lo <= rsDataE;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors with hand-computed results for md_unit.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  hiloOpE = HILO_OP_NONE;
    logic [1:0]  hiloReadE = HILO_RD_NONE;
    logic [31:0] rsDataE = '0;
    logic [31:0] rtDataE = '0;
    logic        isHiloD = 1'b0;
    logic        start, busy, mdStallD;
    logic [31:0] hiloOutE;
    int          n_cmp = 0;
    int          n_err = 0;

    md_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hiloOpE  (hiloOpE),
        .hiloReadE(hiloReadE),
        .rsDataE  (rsDataE),
        .rtDataE  (rtDataE),
        .isHiloD  (isHiloD),
        .start    (start),
        .busy     (busy),
        .hiloOutE (hiloOutE),
        .mdStallD (mdStallD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] he, input logic [31:0] le);
        hiloReadE = HILO_RD_HI;
        #1 chk({tag, "_hi"}, hiloOutE, he);
        hiloReadE = HILO_RD_LO;
        #1 chk({tag, "_lo"}, hiloOutE, le);
        hiloReadE = HILO_RD_NONE;
        #1;
    endtask

    // Issues one md op, checks the busy window cycle by cycle, then the results.
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] hp, input logic [31:0] lp,
                          input logic [31:0] he, input logic [31:0] le);
        hiloOpE = op;
        rsDataE = a;
        rtDataE = b;
        isHiloD = 1'b1;
        #1;
        chk({tag, "_start"}, start, 1);
        chk({tag, "_busy0"}, busy, 0);
        chk({tag, "_stall0"}, mdStallD, 1);
        step;
        hiloOpE = HILO_OP_NONE;
        for (int i = 0; i < n; i++) begin
            #1;
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_nostart"}, start, 0);
            chk({tag, "_stall"}, mdStallD, 1);
            read_hilo({tag, "_hold"}, hp, lp);
            step;
        end
        #1;
        chk({tag, "_done"}, busy, 0);
        chk({tag, "_unstall"}, mdStallD, 0);
        isHiloD = 1'b0;
        read_hilo(tag, he, le);
    endtask

    task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] v,
                      input logic [31:0] he, input logic [31:0] le);
        hiloOpE = op;
        rsDataE = v;
        #1 chk({tag, "_start"}, start, 0);
        step;
        hiloOpE = HILO_OP_NONE;
        chk({tag, "_busy"}, busy, 0);
        read_hilo(tag, he, le);
    endtask

    initial begin
        isHiloD = 1'b1;
        step;
        step;
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_stall", mdStallD, 0);
        read_hilo("rst", 32'h0, 32'h0);
        isHiloD = 1'b0;
        rst_n = 1'b1;
        step;

        run_md("mult", HILO_OP_MULT, 32'hFFFFFFFD, 32'h00000005, 5,
               32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_md("multu", HILO_OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 5,
               32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000001, 32'hFFFFFFFE);
        run_md("div", HILO_OP_DIV, 32'hFFFFFFF9, 32'h00000002, 10,
               32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu", HILO_OP_DIVU, 32'hFFFFFFF9, 32'h00000002, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001, 32'h7FFFFFFC);

        mt("mthi", HILO_OP_MTHI, 32'hABCD0123, 32'hABCD0123, 32'h7FFFFFFC);
        mt("mtlo", HILO_OP_MTLO, 32'h5A5A5A5A, 32'hABCD0123, 32'h5A5A5A5A);
        mt("mthi2", HILO_OP_MTHI, 32'h11111111, 32'h11111111, 32'h5A5A5A5A);
        mt("mtlo2", HILO_OP_MTLO, 32'h22222222, 32'h11111111, 32'h22222222);

        run_md("divz", HILO_OP_DIVU, 32'h12345678, 32'h00000000, 10,
               32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222);

        // Ops arriving while busy must be ignored, then reset lands mid-divide.
        hiloOpE = HILO_OP_DIV;
        rsDataE = 32'd100;
        rtDataE = 32'd7;
        step;
        hiloOpE = HILO_OP_MTHI;
        rsDataE = 32'hDEADBEEF;
        #1 chk("ign_mthi_start", start, 0);
        step;
        hiloOpE = HILO_OP_MULT;
        #1 chk("ign_mult_start", start, 0);
        step;
        hiloOpE = HILO_OP_NONE;
        read_hilo("ign", 32'h11111111, 32'h22222222);
        step;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        read_hilo("arst", 32'h0, 32'h0);
        step;
        rst_n = 1'b1;
        step;
        chk("post_rst_busy", busy, 0);
        run_md("mult2", HILO_OP_MULT, 32'h00000003, 32'h00000004, 5,
               32'h0, 32'h0, 32'h0, 32'h0000000C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
